// File: rtl/ms_dbio_pkg.sv
// Shared definitions for the DBIO serializer: field widths, byte limit, FSM states and
// the request byte-count clamp.
package ms_dbio_pkg;

    localparam int unsigned DbioAddrW    = 12;
    localparam int unsigned DbioDataW    = 64;
    localparam int unsigned DbioIdxW     = 4;
    localparam int unsigned DbioMaxBytes = 8;

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StRd,
        StDone
    } dbio_state_e;

    function automatic logic [DbioIdxW-1:0] clamp_idx(input logic [DbioIdxW-1:0] idx,
                                                      input int unsigned max_bytes);
        return (32'(idx) > max_bytes) ? DbioIdxW'(max_bytes) : idx;
    endfunction

endpackage

// File: rtl/ms_dbio_timer.sv
// Per-byte ack watchdog: loadable down-counter with synchronous clear and a zero flag.
module ms_dbio_timer #(
    parameter int unsigned Width = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ms_dbio_ser.sv
// DBIO request serializer: runs one parallel boot-FSM request as byte-wise debug-bus
// write/read handshakes and gathers the returned read bytes into a 64b word.
module ms_dbio_ser
    import ms_dbio_pkg::*;
#(
    parameter int unsigned CTimeout  = 64,
    parameter int unsigned CMaxBytes = DbioMaxBytes
) (
    input  logic                 AClkH,
    input  logic                 AResetHN,
    input  logic                 AClkHEn,
    input  logic [DbioAddrW-1:0] ADbioAddr,
    input  logic [DbioDataW-1:0] ADbioMosi,
    input  logic [DbioIdxW-1:0]  ADbioMosiIdx,
    input  logic [DbioIdxW-1:0]  ADbioMisoIdx,
    input  logic                 ADbioMosi1st,
    input  logic                 ADbioMiso1st,
    output logic [DbioAddrW-1:0] ASerAddr,
    output logic [7:0]           ASerMosi,
    output logic                 ASerWr,
    output logic                 ASerRd,
    output logic                 ASer1st,
    input  logic                 ASerAck,
    input  logic [7:0]           ASerMiso,
    output logic [DbioDataW-1:0] AMiso,
    output logic                 AMisoValid,
    output logic                 ABusy,
    output logic                 AErr,
    output logic                 ALost
);

    localparam int unsigned TimerW = $clog2(CTimeout);

    dbio_state_e          state_q, state_d;
    logic [DbioIdxW-1:0]  cnt_q, cnt_d, nw_q, nw_d, nr_q, nr_d;
    logic [DbioAddrW-1:0] addr_q, addr_d;
    logic [DbioDataW-1:0] mosi_q, mosi_d, miso_q, miso_d;
    logic                 fw_q, fw_d, fr_q, fr_d, err_q, err_d, lost_q, lost_d;
    logic                 req, tmr_load, tmr_clr, tmr_dec, tmr_zero;
    logic [DbioIdxW-1:0]  cnt_inc;
    logic [5:0]           byte_sel;

    // Idle bus from the boot FSM is all zeros, so any non-zero byte count is a request.
    assign req      = (ADbioMosiIdx != '0) || (ADbioMisoIdx != '0);
    assign cnt_inc  = cnt_q + 4'd1;
    assign byte_sel = {cnt_q[2:0], 3'b000};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        nw_d     = nw_q;
        nr_d     = nr_q;
        addr_d   = addr_q;
        mosi_d   = mosi_q;
        miso_d   = miso_q;
        fw_d     = fw_q;
        fr_d     = fr_q;
        err_d    = err_q;
        lost_d   = lost_q;
        tmr_load = 1'b0;
        tmr_clr  = 1'b0;
        tmr_dec  = 1'b0;
        if (req && (state_q != StIdle)) begin
            lost_d = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d   = ADbioAddr;
                    mosi_d   = ADbioMosi;
                    miso_d   = '0;
                    nw_d     = clamp_idx(ADbioMosiIdx, CMaxBytes);
                    nr_d     = clamp_idx(ADbioMisoIdx, CMaxBytes);
                    fw_d     = ADbioMosi1st;
                    fr_d     = ADbioMiso1st;
                    cnt_d    = '0;
                    tmr_load = 1'b1;
                    state_d  = (ADbioMosiIdx != '0) ? StWr : StRd;
                end
            end
            StWr: begin
                // An ack in the timeout cycle still counts as a transfer.
                if (ASerAck) begin
                    tmr_load = 1'b1;
                    if (cnt_inc == nw_q) begin
                        cnt_d   = '0;
                        state_d = (nr_q != '0) ? StRd : StDone;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (tmr_zero) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StRd: begin
                if (ASerAck) begin
                    tmr_load               = 1'b1;
                    miso_d[byte_sel +: 8]  = ASerMiso;
                    if (cnt_inc == nr_q) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (tmr_zero) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StDone: begin
                tmr_clr = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge AClkH) begin
        if (!AResetHN) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            nw_q    <= '0;
            nr_q    <= '0;
            addr_q  <= '0;
            mosi_q  <= '0;
            miso_q  <= '0;
            fw_q    <= 1'b0;
            fr_q    <= 1'b0;
            err_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else if (AClkHEn) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nw_q    <= nw_d;
            nr_q    <= nr_d;
            addr_q  <= addr_d;
            mosi_q  <= mosi_d;
            miso_q  <= miso_d;
            fw_q    <= fw_d;
            fr_q    <= fr_d;
            err_q   <= err_d;
            lost_q  <= lost_d;
        end
    end

    ms_dbio_timer #(
        .Width(TimerW)
    ) u_timer (
        .clk_i     (AClkH),
        .rst_ni    (AResetHN),
        .en_i      (AClkHEn),
        .clr_i     (tmr_clr),
        .load_i    (tmr_load),
        .load_val_i(TimerW'(CTimeout - 1)),
        .dec_i     (tmr_dec),
        .zero_o    (tmr_zero)
    );

    assign ASerAddr   = addr_q;
    assign ASerWr     = (state_q == StWr);
    assign ASerRd     = (state_q == StRd);
    assign ASerMosi   = ASerWr ? mosi_q[byte_sel +: 8] : 8'h00;
    assign ASer1st    = (cnt_q == '0) && ((ASerWr && fw_q) || (ASerRd && fr_q));
    assign AMiso      = miso_q;
    assign AMisoValid = (state_q == StDone);
    assign ABusy      = (state_q != StIdle);
    assign AErr       = err_q;
    assign ALost      = lost_q;

endmodule

// File: tb/tb_ms_dbio_ser.sv
// Bench for ms_dbio_ser: a transfer-sequence model checked every cycle, directed cases with
// literal expectations, then randomized requests, enables, acks and resets.
module tb_ms_dbio_ser;

    localparam int CTimeout = 64;

    logic        AClkH = 1'b0;
    logic        AResetHN, AClkHEn;
    logic [11:0] ADbioAddr;
    logic [63:0] ADbioMosi;
    logic [3:0]  ADbioMosiIdx, ADbioMisoIdx;
    logic        ADbioMosi1st, ADbioMiso1st;
    logic [11:0] ASerAddr;
    logic [7:0]  ASerMosi, ASerMiso;
    logic        ASerWr, ASerRd, ASer1st, ASerAck;
    logic [63:0] AMiso;
    logic        AMisoValid, ABusy, AErr, ALost;

    int   n_tests = 0;
    int   n_fail = 0;
    int   ack_dly = 0;
    bit   noise = 1'b0;
    bit   chk_on = 1'b0;
    int   srd_cnt = 0;
    int   valid_cnt = 0;
    int   wren_cnt = 0;
    logic [7:0] miso_tab [8];
    logic [7:0] wr_log [$];
    bit         first_log [$];

    // Model: a request is a flat sequence of nw writes then nr reads; m_pos walks it.
    int          m_ph = 0;  // 0 idle, 1 transferring, 2 completion pulse
    int          m_nw = 0, m_nr = 0, m_pos = 0, m_stall = 0;
    logic [11:0] m_addr = '0;
    logic [63:0] m_mosi = '0, m_miso = '0;
    bit          m_fw = 0, m_fr = 0, m_err = 0, m_lost = 0;

    always #5 AClkH = ~AClkH;

    ms_dbio_ser #(
        .CTimeout (64),
        .CMaxBytes(8)
    ) dut (
        .AClkH       (AClkH),
        .AResetHN    (AResetHN),
        .AClkHEn     (AClkHEn),
        .ADbioAddr   (ADbioAddr),
        .ADbioMosi   (ADbioMosi),
        .ADbioMosiIdx(ADbioMosiIdx),
        .ADbioMisoIdx(ADbioMisoIdx),
        .ADbioMosi1st(ADbioMosi1st),
        .ADbioMiso1st(ADbioMiso1st),
        .ASerAddr    (ASerAddr),
        .ASerMosi    (ASerMosi),
        .ASerWr      (ASerWr),
        .ASerRd      (ASerRd),
        .ASer1st     (ASer1st),
        .ASerAck     (ASerAck),
        .ASerMiso    (ASerMiso),
        .AMiso       (AMiso),
        .AMisoValid  (AMisoValid),
        .ABusy       (ABusy),
        .AErr        (AErr),
        .ALost       (ALost)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : model
        bit req;
        forever begin
            @(posedge AClkH);
            if (!AResetHN) begin
                m_ph = 0; m_pos = 0; m_stall = 0; m_nw = 0; m_nr = 0;
                m_addr = '0; m_mosi = '0; m_miso = '0;
                m_fw = 0; m_fr = 0; m_err = 0; m_lost = 0;
            end else if (AClkHEn) begin
                req = (ADbioMosiIdx != 0) || (ADbioMisoIdx != 0);
                if (req && m_ph != 0) m_lost = 1;
                case (m_ph)
                    0: if (req) begin
                        m_addr  = ADbioAddr;
                        m_mosi  = ADbioMosi;
                        m_nw    = (ADbioMosiIdx > 8) ? 8 : int'(ADbioMosiIdx);
                        m_nr    = (ADbioMisoIdx > 8) ? 8 : int'(ADbioMisoIdx);
                        m_fw    = ADbioMosi1st;
                        m_fr    = ADbioMiso1st;
                        m_miso  = '0;
                        m_pos   = 0;
                        m_stall = 0;
                        m_ph    = 1;
                    end
                    1: if (ASerAck) begin
                        if (m_pos >= m_nw) m_miso[8*(m_pos-m_nw) +: 8] = ASerMiso;
                        m_pos++;
                        m_stall = 0;
                        if (m_pos == m_nw + m_nr) m_ph = 2;
                    end else begin
                        m_stall++;
                        if (m_stall == CTimeout) begin
                            m_err = 1;
                            m_ph  = 2;
                        end
                    end
                    default: m_ph = 0;
                endcase
            end
        end
    end

    initial begin : compare
        bit wr_e, rd_e, first_e, live;
        logic [7:0] mosi_e;
        forever begin
            @(negedge AClkH);
            if (chk_on) begin
                wr_e    = (m_ph == 1) && (m_pos < m_nw);
                rd_e    = (m_ph == 1) && (m_pos >= m_nw);
                mosi_e  = wr_e ? m_mosi[8*m_pos +: 8] : 8'h00;
                first_e = (wr_e && m_pos == 0 && m_fw) || (rd_e && m_pos == m_nw && m_fr);
                chk("ser_wr",    64'(ASerWr),     64'(wr_e));
                chk("ser_rd",    64'(ASerRd),     64'(rd_e));
                chk("ser_mosi",  64'(ASerMosi),   64'(mosi_e));
                chk("ser_1st",   64'(ASer1st),    64'(first_e));
                chk("ser_addr",  64'(ASerAddr),   64'(m_addr));
                chk("miso",      AMiso,           m_miso);
                chk("miso_vld",  64'(AMisoValid), 64'(m_ph == 2));
                chk("busy",      64'(ABusy),      64'(m_ph != 0));
                chk("err",       64'(AErr),       64'(m_err));
                chk("lost",      64'(ALost),      64'(m_lost));
                live = AResetHN && AClkHEn;
                if (live && ASerWr && ASerAck) begin
                    wr_log.push_back(ASerMosi);
                    first_log.push_back(ASer1st);
                end
                if (live && AMisoValid) valid_cnt++;
                if (live && ASerWr) wren_cnt++;
            end
        end
    end

    // Slave: acks after ack_dly idle cycles, holds ack until consumed; ack_dly < 0 never acks.
    initial begin : slave
        bit took;
        int wcnt;
        wcnt = 0;
        ASerAck = 1'b0;
        ASerMiso = 8'h00;
        forever begin
            @(negedge AClkH);
            took = ASerAck && AClkHEn && AResetHN && (ASerWr || ASerRd);
            if (took && ASerRd) srd_cnt++;
            @(posedge AClkH);
            #2;
            if (!(ASerWr || ASerRd)) begin
                ASerAck  = noise ? 1'($urandom) : 1'b0;
                ASerMiso = 8'($urandom);
                wcnt     = 0;
            end else if (took || ack_dly < 0) begin
                ASerAck = 1'b0;
                wcnt    = 0;
            end else if (!ASerAck) begin
                if (wcnt >= ack_dly) begin
                    ASerAck  = 1'b1;
                    ASerMiso = miso_tab[srd_cnt % 8];
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge AClkH);
        #1;
    endtask

    task automatic idle_inputs();
        ADbioAddr    = '0;
        ADbioMosi    = '0;
        ADbioMosiIdx = '0;
        ADbioMisoIdx = '0;
        ADbioMosi1st = 1'b0;
        ADbioMiso1st = 1'b0;
    endtask

    task automatic issue(input logic [11:0] a, input logic [63:0] d, input logic [3:0] wi,
                         input logic [3:0] ri, input bit fw, input bit fr);
        cyc();
        AClkHEn      = 1'b1;
        ADbioAddr    = a;
        ADbioMosi    = d;
        ADbioMosiIdx = wi;
        ADbioMisoIdx = ri;
        ADbioMosi1st = fw;
        ADbioMiso1st = fr;
        cyc();
        idle_inputs();
    endtask

    task automatic wait_idle(input int budget, input bit tog);
        for (int i = 0; i < budget && ABusy; i++) begin
            cyc();
            if (tog) AClkHEn = ~AClkHEn;
        end
        chk("wait_idle", 64'(ABusy), 64'd0);
        AClkHEn = 1'b1;
    endtask

    task automatic pulse_reset();
        AResetHN = 1'b0;
        cyc();
        AResetHN = 1'b1;
    endtask

    initial begin : driver
        int base, v0, w0;
        logic [63:0] d;
        logic [7:0] pat [4];
        pat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 8; i++) miso_tab[i] = 8'h00;
        AResetHN = 1'b0;
        AClkHEn  = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        chk_on = 1'b1;
        chk("rst_busy", 64'(ABusy), 64'd0);
        chk("rst_miso", AMiso, 64'd0);
        chk("rst_wr", 64'(ASerWr), 64'd0);
        AResetHN = 1'b1;
        AClkHEn  = 1'b1;

        // Two-byte write.
        ack_dly = 1;
        base = wr_log.size();
        v0 = valid_cnt;
        issue(12'h100, 64'h0001, 4'd2, 4'd0, 1'b1, 1'b0);
        chk("s1_strobe_lat", 64'(ASerWr), 64'd1);
        chk("s1_addr", 64'(ASerAddr), 64'h100);
        wait_idle(100, 1'b0);
        chk("s1_nbytes", 64'(wr_log.size() - base), 64'd2);
        chk("s1_byte0", 64'(wr_log[base]), 64'h01);
        chk("s1_byte1", 64'(wr_log[base+1]), 64'h00);
        chk("s1_first0", 64'(first_log[base]), 64'd1);
        chk("s1_first1", 64'(first_log[base+1]), 64'd0);
        chk("s1_valid", 64'(valid_cnt - v0), 64'd1);
        chk("s1_err", 64'(AErr), 64'd0);

        // Write one byte, read four.
        for (int i = 0; i < 4; i++) miso_tab[(srd_cnt + i) % 8] = pat[i];
        base = wr_log.size();
        v0 = valid_cnt;
        issue(12'h204, 64'h17, 4'd1, 4'd4, 1'b1, 1'b1);
        wait_idle(100, 1'b0);
        chk("s2_miso", AMiso, 64'h00000000DDCCBBAA);
        chk("s2_byte0", 64'(wr_log[base]), 64'h17);
        chk("s2_valid", 64'(valid_cnt - v0), 64'd1);

        // Timeout with no ack.
        ack_dly = -1;
        v0 = valid_cnt;
        w0 = wren_cnt;
        issue(12'h003, 64'h5A, 4'd1, 4'd0, 1'b0, 1'b0);
        wait_idle(200, 1'b0);
        chk("s3_wr_cycles", 64'(wren_cnt - w0), 64'd64);
        chk("s3_err", 64'(AErr), 64'd1);
        chk("s3_valid", 64'(valid_cnt - v0), 64'd1);
        pulse_reset();
        chk("s3_err_clr", 64'(AErr), 64'd0);

        // Second request while busy is lost.
        ack_dly = 2;
        base = wr_log.size();
        v0 = valid_cnt;
        issue(12'h0AB, 64'h00C0FFEE, 4'd3, 4'd0, 1'b1, 1'b0);
        cyc();
        issue(12'h7FF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd2, 4'd2, 1'b1, 1'b1);
        wait_idle(100, 1'b0);
        chk("s4_lost", 64'(ALost), 64'd1);
        chk("s4_nbytes", 64'(wr_log.size() - base), 64'd3);
        chk("s4_byte0", 64'(wr_log[base]), 64'hEE);
        chk("s4_byte2", 64'(wr_log[base+2]), 64'hC0);
        chk("s4_addr", 64'(ASerAddr), 64'h0AB);
        chk("s4_valid", 64'(valid_cnt - v0), 64'd1);

        // Toggling enable, byte count 9 clamped to 8.
        ack_dly = 0;
        base = wr_log.size();
        v0 = valid_cnt;
        d = {$urandom, $urandom};
        issue(12'h5A5, d, 4'd9, 4'd0, 1'b1, 1'b0);
        wait_idle(400, 1'b1);
        chk("s5_nbytes", 64'(wr_log.size() - base), 64'd8);
        for (int i = 0; i < 8; i++) chk("s5_byte", 64'(wr_log[base+i]), 64'(d[8*i +: 8]));
        chk("s5_valid", 64'(valid_cnt - v0), 64'd1);

        // Reset during a read with enable low.
        pulse_reset();
        ack_dly = -1;
        issue(12'h055, 64'h0, 4'd0, 4'd3, 1'b0, 1'b1);
        cyc();
        cyc();
        chk("s6_in_rd", 64'(ASerRd), 64'd1);
        AClkHEn  = 1'b0;
        AResetHN = 1'b0;
        v0 = valid_cnt;
        cyc();
        chk("s6_busy", 64'(ABusy), 64'd0);
        chk("s6_rd", 64'(ASerRd), 64'd0);
        chk("s6_addr", 64'(ASerAddr), 64'd0);
        AResetHN = 1'b1;
        AClkHEn  = 1'b1;
        repeat (5) cyc();
        chk("s6_no_valid", 64'(valid_cnt - v0), 64'd0);

        // Random traffic.
        for (int blk = 0; blk < 6; blk++) begin
            noise = blk[0];
            for (int c = 0; c < 1500; c++) begin
                cyc();
                if (c % 200 == 0) ack_dly = ($urandom % 8 == 0) ? -1 : int'($urandom % 4);
                AClkHEn  = (blk < 2) ? 1'b1 : ($urandom % 3 != 0);
                AResetHN = ($urandom % 400 != 0);
                if ($urandom % 8 == 0) begin
                    ADbioAddr    = 12'($urandom);
                    ADbioMosi    = {$urandom, $urandom};
                    ADbioMosiIdx = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom);
                    ADbioMisoIdx = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom);
                    ADbioMosi1st = 1'($urandom);
                    ADbioMiso1st = 1'($urandom);
                end else begin
                    idle_inputs();
                end
                if ($urandom % 64 == 0) miso_tab[$urandom % 8] = 8'($urandom);
            end
        end
        idle_inputs();
        AResetHN = 1'b1;
        AClkHEn  = 1'b1;
        repeat (3) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
